md_sched: RTL and testbench

- Sequencer for the multiply/divide (HI/LO) resource in the 5-stage MIPS pipeline.
- Accepts MD instructions from the E stage and models multi-cycle latency with a countdown.
- Holds HI/LO and produces the busy/stall request consumed by the hazard control unit (HCU).
- Supplies the mfhi/mflo read value, which travels down the pipe to the W-stage write-back mux (MD data source).

---
 rtl/md_sched_pkg.sv | 34 +++
 rtl/md_sched_if.sv | 34 +++
 rtl/md_sched_arith.sv | 63 ++++++
 rtl/md_sched.sv | 137 +++++++++++++
 tb/tb_md_sched.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/md_sched_pkg.sv
// -----------------------------------------------------------------------------
// md_sched_pkg
// Shared definitions for the multiply/divide (HI/LO) sequencer:
//   - md_op encodings driven by the E stage
//   - default busy latencies for multiply and divide
//   - predicates used by the sequencer and its stall logic
// -----------------------------------------------------------------------------
package md_sched_pkg;

    typedef enum logic [3:0] {
        MD_NONE = 4'd0,
        MULT    = 4'd1,
        MULTU   = 4'd2,
        DIV     = 4'd3,
        DIVU    = 4'd4,
        MTHI    = 4'd5,
        MTLO    = 4'd6,
        MFHI    = 4'd7,
        MFLO    = 4'd8
    } md_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Ops that occupy the unit for a multi-cycle countdown.
    function automatic logic is_mul_div(md_op_e op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic is_mult(md_op_e op);
        return (op == MULT) || (op == MULTU);
    endfunction

endpackage

// File: rtl/md_sched_if.sv
// -----------------------------------------------------------------------------
// md_sched_if
// Bus between the E stage / hazard control unit and the MD sequencer.
//   start, md_op, rs_val, rt_val, cancel, d_md_use : pipeline -> sequencer
//   busy, start_out, md_stall, md_rd, hi, lo        : sequencer -> pipeline
// master: pipeline side, slave: md_sched.
// -----------------------------------------------------------------------------
interface md_sched_if;
    import md_sched_pkg::*;

    logic        start;
    md_op_e      md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        cancel;
    logic        d_md_use;
    logic        busy;
    logic        start_out;
    logic        md_stall;
    logic [31:0] md_rd;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, rs_val, rt_val, cancel, d_md_use,
        input  busy, start_out, md_stall, md_rd, hi, lo
    );

    modport slave (
        input  start, md_op, rs_val, rt_val, cancel, d_md_use,
        output busy, start_out, md_stall, md_rd, hi, lo
    );

endinterface

// File: rtl/md_sched_arith.sv
// -----------------------------------------------------------------------------
// md_arith
// Purely combinational MD datapath. Produces the 64-bit {hi_n, lo_n} result
// that the sequencer latches into its shadow register on accept.
//   md_op_i : operation code
//   rs_i    : rs operand (multiplicand / dividend)
//   rt_i    : rt operand (multiplier / divisor)
//   res_o   : {hi_n, lo_n}; zero for non-arithmetic ops
// Division: lo = quotient (truncated toward zero), hi = remainder (sign of
// dividend). Divide by zero gives lo = all ones, hi = dividend; the signed
// overflow case 0x8000_0000 / -1 gives lo = 0x8000_0000, hi = 0.
// -----------------------------------------------------------------------------
module md_arith
    import md_sched_pkg::*;
(
    input  md_op_e      md_op_i,
    input  logic [31:0] rs_i,
    input  logic [31:0] rt_i,
    output logic [63:0] res_o
);

    logic signed [31:0] rs_s;
    logic signed [31:0] rt_s;
    logic signed [63:0] rs_x;
    logic signed [63:0] rt_x;
    logic        [63:0] prod_u;
    logic signed [63:0] prod_s;

    assign rs_s   = rs_i;
    assign rt_s   = rt_i;
    assign rs_x   = {{32{rs_i[31]}}, rs_i};
    assign rt_x   = {{32{rt_i[31]}}, rt_i};
    assign prod_s = rs_x * rt_x;
    assign prod_u = {32'd0, rs_i} * {32'd0, rt_i};

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch is inferred.
    always_comb begin
        res_o = '0;
        case (md_op_i)
            MULT:  res_o = prod_s;
            MULTU: res_o = prod_u;
            DIV: begin
                // Corner cases are resolved before dividing so the divider
                // never sees a zero divisor or the overflowing quotient.
                if (rt_i == 32'd0)
                    res_o = {rs_i, 32'hFFFF_FFFF};
                else if (rs_i == 32'h8000_0000 && rt_i == 32'hFFFF_FFFF)
                    res_o = {32'd0, 32'h8000_0000};
                else
                    res_o = {$unsigned(rs_s % rt_s), $unsigned(rs_s / rt_s)};
            end
            DIVU: begin
                if (rt_i == 32'd0)
                    res_o = {rs_i, 32'hFFFF_FFFF};
                else
                    res_o = {rs_i % rt_i, rs_i / rt_i};
            end
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// -----------------------------------------------------------------------------
// md_sched
// Sequencer for the HI/LO multiply/divide resource of the 5-stage pipeline.
// Accepts MD ops from E, models multi-cycle latency with a countdown, owns
// HI/LO and raises the stall request for the hazard control unit.
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : md_sched_if.slave (start/md_op/operands/cancel/d_md_use in;
//           busy/start_out/md_stall/md_rd/hi/lo out)
// Parameters: MULT_CYCLES, DIV_CYCLES (busy cycles, >= 1).
// Optional build macro MD_ZERO_SKIP_EN: a multiply with a zero operand
// finishes after a single busy cycle; divide latency is unaffected.
// -----------------------------------------------------------------------------
module md_sched
    import md_sched_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input logic        clk,
    input logic        reset,
    md_sched_if.slave  bus
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]       state_q,     state_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic [31:0]      hi_q,        hi_d;
    logic [31:0]      lo_q,        lo_d;
    logic [63:0]      shadow_q,    shadow_d;
    logic             start_out_q, start_out_d;
    logic [63:0]      arith_res;
    logic             accept;
    logic             zero_operand;

    md_arith u_arith (
        .md_op_i (bus.md_op),
        .rs_i    (bus.rs_val),
        .rt_i    (bus.rt_val),
        .res_o   (arith_res)
    );

    // A start while BUSY is never issued (the HCU stalls it) and is ignored.
    assign accept       = bus.start && !bus.cancel && (state_q == ST_IDLE);
    assign zero_operand = (bus.rs_val == 32'd0) || (bus.rt_val == 32'd0);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        shadow_d    = shadow_q;
        start_out_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mul_div(bus.md_op)) begin
                        shadow_d    = arith_res;
                        state_d     = ST_BUSY;
                        start_out_d = 1'b1;
                        if (is_mult(bus.md_op)) begin
`ifdef MD_ZERO_SKIP_EN
                            count_d = zero_operand ? CNT_W'(1) : CNT_W'(MULT_CYCLES);
`else
                            count_d = CNT_W'(MULT_CYCLES);
`endif
                        end else begin
                            count_d = CNT_W'(DIV_CYCLES);
                        end
                    end else if (bus.md_op == MTHI) begin
                        hi_d = bus.rs_val;
                    end else if (bus.md_op == MTLO) begin
                        lo_d = bus.rs_val;
                    end
                end
            end
            ST_BUSY: begin
                // cancel is deliberately ignored here: the op committed at accept.
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    {hi_d, lo_d} = shadow_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            shadow_q    <= '0;
            start_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            shadow_q    <= shadow_d;
            start_out_q <= start_out_d;
        end
    end

`ifndef MD_ZERO_SKIP_EN
    logic unused_zero_operand;
    assign unused_zero_operand = zero_operand;
`endif

    always_comb begin
        case (bus.md_op)
            MFHI:    bus.md_rd = hi_q;
            MFLO:    bus.md_rd = lo_q;
            default: bus.md_rd = '0;
        endcase
    end

    // Stall also covers the issue cycle so the next MD op in D never slips
    // past a multiply/divide that is only just being accepted.
    assign bus.md_stall  = bus.d_md_use &&
                           ((state_q == ST_BUSY) ||
                            (bus.start && !bus.cancel && is_mul_div(bus.md_op)));
    assign bus.busy      = (state_q == ST_BUSY);
    assign bus.start_out = start_out_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// -----------------------------------------------------------------------------
// tb_md_sched
// Self-checking bench for md_sched. Stimulus pushes the expected completion
// {busy length, hi, lo} of every accepted multiply/divide into a scoreboard
// queue; a monitor on the falling clock edge pops and compares whenever busy
// drops. Immediate effects (reset state, mthi/mtlo, mfhi/mflo, cancel, issue
// stall) are checked inline.
// -----------------------------------------------------------------------------
module tb_md_sched;
    import md_sched_pkg::*;

    typedef struct {
        int          len;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

`ifdef MD_ZERO_SKIP_EN
    localparam int ZERO_MULT_LEN = 1;
`else
    localparam int ZERO_MULT_LEN = 5;
`endif

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    exp_t sb_q[$];

    md_sched_if bus ();

    md_sched dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: act=%h req=%h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int len, input logic [31:0] hi, input logic [31:0] lo);
        exp_t e;
        e.len = len;
        e.hi  = hi;
        e.lo  = lo;
        sb_q.push_back(e);
    endtask

    // One-cycle issue; the stall value is checked while start is presented.
    task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic cncl, input logic exp_stall, input string name);
        @(posedge clk);
        #1;
        bus.start  = 1'b1;
        bus.md_op  = op;
        bus.rs_val = a;
        bus.rt_val = b;
        bus.cancel = cncl;
        #1;
        check(name, {31'd0, bus.md_stall}, {31'd0, exp_stall});
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.md_op  = MD_NONE;
        bus.cancel = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!bus.busy) done = 1'b1;
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    // Scoreboard monitor.
    initial begin
        int   busy_len;
        logic prev_busy;
        exp_t e;
        busy_len  = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                busy_len  = 0;
                prev_busy = 1'b0;
            end else begin
                if (bus.busy) begin
                    busy_len++;
                    if (bus.d_md_use) check("stall_busy", {31'd0, bus.md_stall}, 32'd1);
                    check("start_out", {31'd0, bus.start_out}, {31'd0, busy_len == 1});
                end else if (prev_busy) begin
                    if (sb_q.size() == 0) begin
                        check("sb_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_len", busy_len, e.len);
                        check("sb_hi",  bus.hi,   e.hi);
                        check("sb_lo",  bus.lo,   e.lo);
                    end
                    busy_len = 0;
                end
                prev_busy = bus.busy;
            end
        end
    end

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.md_op    = MD_NONE;
        bus.rs_val   = '0;
        bus.rt_val   = '0;
        bus.cancel   = 1'b0;
        bus.d_md_use = 1'b1;

        // Reset state.
        #2;
        check("rst_busy",      {31'd0, bus.busy},      32'd0);
        check("rst_start_out", {31'd0, bus.start_out}, 32'd0);
        check("rst_hi",        bus.hi,                 32'd0);
        check("rst_lo",        bus.lo,                 32'd0);
        check("rst_stall",     {31'd0, bus.md_stall},  32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // mult -3 * 7 = -21.
        push_exp(5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        issue(MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b1, "stall_issue_mult");
        wait_idle("idle_mult");

        // divu 100 / 7, then mflo straight after completion.
        push_exp(10, 32'd2, 32'd14);
        issue(DIVU, 32'd100, 32'd7, 1'b0, 1'b1, "stall_issue_divu");
        wait_idle("idle_divu");
        bus.md_op = MFLO;
        #1;
        check("mflo_after_divu", bus.md_rd, 32'd14);
        bus.md_op = MD_NONE;

        // Signed overflow and divide by zero.
        push_exp(10, 32'd0, 32'h8000_0000);
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, "stall_issue_ovf");
        wait_idle("idle_ovf");
        push_exp(10, 32'd5, 32'hFFFF_FFFF);
        issue(DIV, 32'd5, 32'd0, 1'b0, 1'b1, "stall_issue_div0");
        wait_idle("idle_div0");
        push_exp(10, 32'd9, 32'hFFFF_FFFF);
        issue(DIVU, 32'd9, 32'd0, 1'b0, 1'b1, "stall_issue_divu0");
        wait_idle("idle_divu0");

        // multu 0xFFFF_FFFF * 2 = 0x1_FFFF_FFFE.
        push_exp(5, 32'd1, 32'hFFFF_FFFE);
        issue(MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b1, "stall_issue_multu");
        wait_idle("idle_multu");

        // div -7 / 2 = -3 rem -1, with cancel asserted mid-flight.
        push_exp(10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, "stall_issue_divneg");
        bus.cancel = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.cancel = 1'b0;
        wait_idle("idle_divneg");

        // mthi / mtlo: immediate write, no busy, no stall.
        issue(MTHI, 32'h0000_1234, 32'd0, 1'b0, 1'b0, "stall_issue_mthi");
        check("mthi_hi",   bus.hi, 32'h0000_1234);
        check("mthi_busy", {31'd0, bus.busy}, 32'd0);
        issue(MTLO, 32'h0000_5678, 32'd0, 1'b0, 1'b0, "stall_issue_mtlo");
        check("mtlo_lo", bus.lo, 32'h0000_5678);
        bus.md_op = MFHI;
        #1;
        check("mfhi_rd", bus.md_rd, 32'h0000_1234);
        bus.md_op = MD_NONE;

        // Cancelled mult: nothing latched.
        issue(MULT, 32'd3, 32'd4, 1'b1, 1'b0, "stall_issue_cancel");
        check("cancel_busy",      {31'd0, bus.busy},      32'd0);
        check("cancel_start_out", {31'd0, bus.start_out}, 32'd0);
        @(negedge clk);
        check("cancel_hi", bus.hi, 32'h0000_1234);
        check("cancel_lo", bus.lo, 32'h0000_5678);

        // Reset while a div has count == 4.
        issue(DIV, 32'd100, 32'd3, 1'b0, 1'b1, "stall_issue_rstdiv");
        repeat (6) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_hi",   bus.hi,            32'd0);
        check("midrst_lo",   bus.lo,            32'd0);
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;

        // Zero-operand mult after reset, then a normal mult without D-use.
        push_exp(ZERO_MULT_LEN, 32'd0, 32'd0);
        issue(MULT, 32'd0, 32'd9, 1'b0, 1'b1, "stall_issue_zero");
        wait_idle("idle_zero");
        bus.d_md_use = 1'b0;
        push_exp(5, 32'd0, 32'd42);
        issue(MULT, 32'd6, 32'd7, 1'b0, 1'b0, "stall_issue_nouse");
        @(negedge clk);
        check("stall_nouse_busy", {31'd0, bus.md_stall}, 32'd0);
        wait_idle("idle_nouse");

        repeat (2) @(negedge clk);
        check("sb_drain", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
